sdram_arbit: RTL and testbench
==============================

# sdram_arbit

Central arbiter of the SDRAM controller. Holds the bus in INIT until initialisation completes, then grants the SDRAM command/address bus to exactly one of the auto-refresh, write or read engines. It issues one-cycle enable pulses (`ref_en`, `wr_en`, `rd_en`) and waits for each engine's end flag. It also multiplexes the granted engine's command and address onto the SDRAM pins.

## Interface
Parameters:
- `ADDR_W`, 12: SDRAM address width.
- `BANK_W`, 2: SDRAM bank address width.

Ports (one clock; reset is synchronous and active-low):
- `sclk`  in  1  system clock, 50 MHz.
- `s_rst_n`  in  1  synchronous active-low reset.
- `flag_init_end`  in  1  init engine done; level, stays high.
- `init_cmd`  in  4  init engine command {cs_n, ras_n, cas_n, we_n}.
- `init_addr`  in  ADDR_W  init engine address.
- `ref_req`  in  1  refresh request; may be a single-cycle pulse.
- `flag_ref_end`  in  1  refresh sequence done.
- `aref_cmd`  in  4  refresh engine command.
- `aref_addr`  in  ADDR_W  refresh engine address.
- `wr_req`  in  1  write request; level, held until `wr_en`.
- `flag_wr_end`  in  1  write burst done.
- `wr_cmd`  in  4  write engine command.
- `wr_addr`  in  ADDR_W  write engine address.
- `wr_bank`  in  BANK_W  write engine bank.
- `rd_req`  in  1  read request; level, held until `rd_en`.
- `flag_rd_end`  in  1  read burst done.
- `rd_cmd`  in  4  read engine command.
- `rd_addr`  in  ADDR_W  read engine address.
- `rd_bank`  in  BANK_W  read engine bank.
- `ref_en`  out  1  refresh grant pulse.
- `wr_en`  out  1  write grant pulse.
- `rd_en`  out  1  read grant pulse.
- `sdram_cke`  out  1  clock enable; constant 1.
- `sdram_cmd`  out  4  muxed command.
- `sdram_addr`  out  ADDR_W  muxed address.
- `sdram_bank`  out  BANK_W  muxed bank.

## Operation
- State machine with five states: INIT, ARBIT, AREF, WRITE, READ.
- INIT → ARBIT when `flag_init_end`=1.
- Refresh pending latch `ref_pend`:
  - set by `ref_req`=1 in any state, including INIT;
  - cleared in the cycle `ref_en` is issued;
  - when set and clear coincide, set wins.
- In ARBIT, priority is: `ref_pend` (or `ref_req` this cycle) → AREF, else write/read.
- Write/read fairness:
  - with only one of `wr_req`/`rd_req` high, grant it;
  - with both high, grant the one not served last;
  - register `last_wr` resets to 0, so write wins the first tie.
- Grant pulse: the enable is registered high for exactly one cycle, the first cycle in AREF/WRITE/READ. No enable is ever high in INIT or ARBIT, and at most one enable is high per cycle.
- AREF/WRITE/READ → ARBIT on the matching `flag_*_end`=1. A flag_end from a non-granted engine is ignored.
- Output mux (combinational on state):
  - INIT: init_cmd/init_addr, bank 0.
  - ARBIT: NOP (4'b0111), addr 0, bank 0.
  - AREF: aref_cmd/aref_addr, bank 0.
  - WRITE: wr_cmd/wr_addr/wr_bank.
  - READ: rd_cmd/rd_addr/rd_bank.
- Reset values: state INIT, `ref_pend` 0, `last_wr` 0, all enables 0, `sdram_cke` 1, sdram_cmd/addr follow `init_cmd`/`init_addr`.

## Timing
- Grant latency: a request seen in ARBIT at cycle n gives state plus enable at cycle n+1.
- A refresh arriving mid-WRITE/READ waits until the burst ends. The worst case is one burst plus 2 cycles.
- End flag at cycle n → ARBIT at n+1. A new grant is possible at n+2, so ARBIT lasts at least 1 cycle and the bus drives NOP between engines.
- Reset mid-operation: the next cycle is INIT with enables 0 and pending state cleared, whatever the prior state.
- `flag_init_end` falling after INIT has no effect.

## Structure
- Package `sdram_pkg` holds:
  - CMD_NOP 4'b0111, CMD_AREF 4'b0001, CMD_PRE 4'b0010, CMD_ACT 4'b0011, CMD_WR 4'b0100, CMD_RD 4'b0101;
  - the state enum (INIT, ARBIT, AREF, WRITE, READ).
- FSM and arbitration stay in `sdram_arbit`.
- The output mux is a natural sub-module, `sdram_cmd_mux`: state in, cmd/addr/bank out, purely combinational.

## Test plan
- Reset with init_cmd=4'b0010, init_addr=12'h400 → sdram_cmd=4'b0010 and addr=12'h400 while in INIT; all enables 0. Raise `flag_init_end` → ARBIT next cycle, cmd 4'b0111.
- In ARBIT, one-cycle `ref_req` → `ref_en` high exactly 1 cycle, sdram_cmd=aref_cmd. `flag_ref_end` → NOP the next cycle.
- `wr_req` held and `flag_wr_end` after 8 cycles; `ref_req` pulse at cycle 3 of the write → no `ref_en` until after write end; `ref_en` 2 cycles after `flag_wr_end`.
- `wr_req` and `rd_req` both held continuously, each burst ending after 4 cycles → grants alternate wr, rd, wr, rd; each enable pulses once per grant.
- `ref_req`, `wr_req` and `rd_req` all in the same ARBIT cycle → AREF first, then WRITE, then READ.
- Assert `s_rst_n`=0 for 1 cycle during READ → INIT next cycle, `rd_en` 0, `ref_pend` cleared (no `ref_en` after re-init without a new `ref_req`).

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings and arbiter state type.
package sdram_pkg;

  // Commands are {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef enum logic [2:0] {
    StInit,
    StArbit,
    StAref,
    StWrite,
    StRead
  } state_e;

endpackage

// File: rtl/sdram_arbit_if.sv
// Engine-side handshakes and SDRAM pin bundle seen by the arbiter.
interface sdram_arbit_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BANK_W = 2
) ();

  logic              flag_init_end;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;

  logic              ref_req;
  logic              flag_ref_end;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              flag_wr_end;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;

  logic              rd_req;
  logic              flag_rd_end;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;

  logic              ref_en;
  logic              wr_en;
  logic              rd_en;

  logic              sdram_cke;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;

  // Arbiter side
  modport master (
    input  flag_init_end, init_cmd, init_addr,
    input  ref_req, flag_ref_end, aref_cmd, aref_addr,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en,
    output sdram_cke, sdram_cmd, sdram_addr, sdram_bank
  );

  // Engines / pin side
  modport slave (
    output flag_init_end, init_cmd, init_addr,
    output ref_req, flag_ref_end, aref_cmd, aref_addr,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cmd, sdram_addr, sdram_bank
  );

endinterface

// File: rtl/sdram_cmd_mux.sv
// Routes the granted engine's command/address/bank onto the SDRAM pins.
module sdram_cmd_mux
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BANK_W = 2
) (
  input  state_e            state_i,
  input  logic [3:0]        init_cmd_i,
  input  logic [ADDR_W-1:0] init_addr_i,
  input  logic [3:0]        aref_cmd_i,
  input  logic [ADDR_W-1:0] aref_addr_i,
  input  logic [3:0]        wr_cmd_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic [3:0]        rd_cmd_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [BANK_W-1:0] rd_bank_i,
  output logic [3:0]        cmd_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [BANK_W-1:0] bank_o
);

  // Select pin drivers from the current state; ARBIT parks the bus on NOP
  always_comb begin
    cmd_o  = CMD_NOP;
    addr_o = '0;
    bank_o = '0;
    case (state_i)
      StInit: begin
        cmd_o  = init_cmd_i;
        addr_o = init_addr_i;
      end
      StAref: begin
        cmd_o  = aref_cmd_i;
        addr_o = aref_addr_i;
      end
      StWrite: begin
        cmd_o  = wr_cmd_i;
        addr_o = wr_addr_i;
        bank_o = wr_bank_i;
      end
      StRead: begin
        cmd_o  = rd_cmd_i;
        addr_o = rd_addr_i;
        bank_o = rd_bank_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sdram_arbit.sv
// Central SDRAM arbiter: holds INIT until init completes, then grants the bus to
// refresh (highest priority) or to write/read with round-robin on ties.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BANK_W = 2
) (
  input logic           sclk,
  input logic           s_rst_n,
  sdram_arbit_if.master bus
);

  state_e state_q;
  logic   ref_pend_q, ref_pend_d;
  logic   last_wr_q;
  logic   ref_en_q, wr_en_q, rd_en_q;
  logic   ref_hit;

  // A request arriving in the same cycle as the grant must not be lost, so set wins
  always_comb begin
    ref_pend_d = bus.ref_req | (ref_pend_q & ~ref_en_q);
  end

  assign ref_hit = ref_pend_q | bus.ref_req;

  // Arbitration FSM with registered one-cycle grant pulses
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q    <= StInit;
      ref_pend_q <= 1'b0;
      last_wr_q  <= 1'b0;
      ref_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      ref_pend_q <= ref_pend_d;
      ref_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      case (state_q)
        StInit: begin
          if (bus.flag_init_end) state_q <= StArbit;
        end
        StArbit: begin
          if (ref_hit) begin
            state_q  <= StAref;
            ref_en_q <= 1'b1;
          end else if (bus.wr_req && (!bus.rd_req || !last_wr_q)) begin
            state_q   <= StWrite;
            wr_en_q   <= 1'b1;
            last_wr_q <= 1'b1;
          end else if (bus.rd_req) begin
            state_q   <= StRead;
            rd_en_q   <= 1'b1;
            last_wr_q <= 1'b0;
          end
        end
        StAref: begin
          if (bus.flag_ref_end) state_q <= StArbit;
        end
        StWrite: begin
          if (bus.flag_wr_end) state_q <= StArbit;
        end
        StRead: begin
          if (bus.flag_rd_end) state_q <= StArbit;
        end
        default: state_q <= StInit;
      endcase
    end
  end

  assign bus.ref_en    = ref_en_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.sdram_cke = 1'b1;

  sdram_cmd_mux #(
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W)
  ) u_cmd_mux (
    .state_i     (state_q),
    .init_cmd_i  (bus.init_cmd),
    .init_addr_i (bus.init_addr),
    .aref_cmd_i  (bus.aref_cmd),
    .aref_addr_i (bus.aref_addr),
    .wr_cmd_i    (bus.wr_cmd),
    .wr_addr_i   (bus.wr_addr),
    .wr_bank_i   (bus.wr_bank),
    .rd_cmd_i    (bus.rd_cmd),
    .rd_addr_i   (bus.rd_addr),
    .rd_bank_i   (bus.rd_bank),
    .cmd_o       (bus.sdram_cmd),
    .addr_o      (bus.sdram_addr),
    .bank_o      (bus.sdram_bank)
  );

endmodule

// File: tb/tb_sdram_arbit.sv
// Scoreboard bench for sdram_arbit: expected grants (kind, cycle) are queued as
// stimulus is driven and matched against every enable pulse the DUT issues.
module tb_sdram_arbit;
  import sdram_pkg::*;

  localparam int KRef  = 0;
  localparam int KWr   = 1;
  localparam int KRd   = 2;
  localparam int KNone = -1;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  logic clk;
  logic s_rst_n;
  int   cyc;
  int   c;
  int   n_vec;
  int   n_miscmp;
  exp_t exp_q[$];

  // Engine models
  int   ref_len, wr_len, rd_len;
  int   ref_left, wr_left, rd_left;
  int   wr_issued, wr_granted, rd_issued, rd_granted;
  logic ref_flag, wr_flag, rd_flag;
  logic stray_ref, stray_rd;

  sdram_arbit_if #(.ADDR_W(12), .BANK_W(2)) bus ();

  sdram_arbit #(
    .ADDR_W (12),
    .BANK_W (2)
  ) dut (
    .sclk    (clk),
    .s_rst_n (s_rst_n),
    .bus     (bus)
  );

  assign bus.flag_ref_end = ref_flag | stray_ref;
  assign bus.flag_wr_end  = wr_flag;
  assign bus.flag_rd_end  = rd_flag | stray_rd;
  assign bus.wr_req       = (wr_issued != wr_granted);
  assign bus.rd_req       = (rd_issued != rd_granted);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor grants and model the engines, sampling 1 time unit after each edge
  initial begin
    int   got;
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.ref_en || bus.wr_en || bus.rd_en) begin
        got = bus.ref_en ? KRef : (bus.wr_en ? KWr : KRd);
        check_eq("en_onehot", $countones({bus.ref_en, bus.wr_en, bus.rd_en}), 1);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_grant", got, KNone);
        end else begin
          e = exp_q.pop_front();
          check_eq("grant_kind", got, e.kind);
          check_eq("grant_cycle", cyc, e.at);
          case (got)
            KRef: begin
              check_eq("grant_cmd", int'(bus.sdram_cmd), int'(CMD_AREF));
              check_eq("grant_addr", int'(bus.sdram_addr), 'h111);
              check_eq("grant_bank", int'(bus.sdram_bank), 0);
            end
            KWr: begin
              check_eq("grant_cmd", int'(bus.sdram_cmd), int'(CMD_WR));
              check_eq("grant_addr", int'(bus.sdram_addr), 'h222);
              check_eq("grant_bank", int'(bus.sdram_bank), 1);
            end
            default: begin
              check_eq("grant_cmd", int'(bus.sdram_cmd), int'(CMD_RD));
              check_eq("grant_addr", int'(bus.sdram_addr), 'h333);
              check_eq("grant_bank", int'(bus.sdram_bank), 2);
            end
          endcase
        end
      end
      // Engines: on a grant, hold for len cycles, flag_end on the last one
      if (!s_rst_n) begin
        ref_left = 0;
        wr_left  = 0;
        rd_left  = 0;
      end else begin
        if (bus.ref_en) ref_left = ref_len;
        if (bus.wr_en) begin
          wr_left = wr_len;
          wr_granted++;
        end
        if (bus.rd_en) begin
          rd_left = rd_len;
          rd_granted++;
        end
      end
      ref_flag = (ref_left == 1);
      wr_flag  = (wr_left == 1);
      rd_flag  = (rd_left == 1);
      if (ref_left > 0) ref_left--;
      if (wr_left > 0) wr_left--;
      if (rd_left > 0) rd_left--;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc = 0; n_vec = 0; n_miscmp = 0;
    ref_left = 0; wr_left = 0; rd_left = 0;
    ref_flag = 1'b0; wr_flag = 1'b0; rd_flag = 1'b0;
    stray_ref = 1'b0; stray_rd = 1'b0;
    wr_issued = 0; wr_granted = 0; rd_issued = 0; rd_granted = 0;
    ref_len = 3; wr_len = 8; rd_len = 2;
    s_rst_n = 1'b0;
    bus.flag_init_end = 1'b0;
    bus.init_cmd  = 4'b0010;
    bus.init_addr = 12'h400;
    bus.ref_req   = 1'b0;
    bus.aref_cmd  = CMD_AREF;
    bus.aref_addr = 12'h111;
    bus.wr_cmd    = CMD_WR;
    bus.wr_addr   = 12'h222;
    bus.wr_bank   = 2'd1;
    bus.rd_cmd    = CMD_RD;
    bus.rd_addr   = 12'h333;
    bus.rd_bank   = 2'd2;

    // Reset: INIT drives init engine, no enables, cke high
    tick(3);
    check_eq("rst_cmd", int'(bus.sdram_cmd), 'b0010);
    check_eq("rst_addr", int'(bus.sdram_addr), 'h400);
    check_eq("rst_bank", int'(bus.sdram_bank), 0);
    check_eq("rst_en", int'({bus.ref_en, bus.wr_en, bus.rd_en}), 0);
    check_eq("rst_cke", int'(bus.sdram_cke), 1);
    s_rst_n = 1'b1;
    tick(2);
    check_eq("init_hold_cmd", int'(bus.sdram_cmd), 'b0010);

    // Refresh requested during INIT is remembered until ARBIT
    bus.ref_req = 1'b1;
    tick(1);
    bus.ref_req = 1'b0;
    c = cyc;
    bus.flag_init_end = 1'b1;
    push_exp(KRef, c + 2);
    tick(1);
    check_eq("arbit_nop_cmd", int'(bus.sdram_cmd), int'(CMD_NOP));
    check_eq("arbit_nop_addr", int'(bus.sdram_addr), 0);
    tick(1);
    bus.flag_init_end = 1'b0;
    tick(3);
    check_eq("post_init_aref_nop", int'(bus.sdram_cmd), int'(CMD_NOP));

    // Single-cycle ref_req in ARBIT
    c = cyc;
    bus.ref_req = 1'b1;
    push_exp(KRef, c + 1);
    tick(1);
    bus.ref_req = 1'b0;
    tick(1);
    check_eq("aref_hold_cmd", int'(bus.sdram_cmd), int'(CMD_AREF));
    check_eq("aref_en_once", int'(bus.ref_en), 0);
    tick(2);
    check_eq("post_aref_nop", int'(bus.sdram_cmd), int'(CMD_NOP));

    // Write of 8 cycles; refresh arriving mid-burst waits; stray end flags ignored
    c = cyc;
    wr_issued++;
    push_exp(KWr, c + 1);
    tick(3);
    bus.ref_req = 1'b1;
    push_exp(KRef, c + 10);
    tick(1);
    bus.ref_req = 1'b0;
    tick(1);
    stray_ref = 1'b1;
    stray_rd  = 1'b1;
    tick(1);
    stray_ref = 1'b0;
    stray_rd  = 1'b0;
    check_eq("wr_hold_cmd", int'(bus.sdram_cmd), int'(CMD_WR));
    tick(3);
    check_eq("wr_end_nop", int'(bus.sdram_cmd), int'(CMD_NOP));
    check_eq("wr_end_no_ref_en", int'(bus.ref_en), 0);
    tick(4);

    // Lone read
    c = cyc;
    rd_issued++;
    push_exp(KRd, c + 1);
    tick(3);

    // Both held: alternation starting with write (read was served last)
    wr_len = 4;
    rd_len = 4;
    c = cyc;
    wr_issued += 2;
    rd_issued += 2;
    push_exp(KWr, c + 1);
    push_exp(KRd, c + 6);
    push_exp(KWr, c + 11);
    push_exp(KRd, c + 16);
    tick(20);
    check_eq("alt_end_nop", int'(bus.sdram_cmd), int'(CMD_NOP));

    // All three in one ARBIT cycle: refresh, then write, then read
    c = cyc;
    bus.ref_req = 1'b1;
    wr_issued++;
    rd_issued++;
    push_exp(KRef, c + 1);
    push_exp(KWr, c + 5);
    push_exp(KRd, c + 10);
    tick(1);
    bus.ref_req = 1'b0;
    tick(13);

    // Reset during READ clears pending refresh
    rd_len = 10;
    c = cyc;
    rd_issued++;
    push_exp(KRd, c + 1);
    tick(2);
    bus.ref_req = 1'b1;
    tick(1);
    bus.ref_req = 1'b0;
    s_rst_n = 1'b0;
    tick(1);
    check_eq("mid_rst_cmd", int'(bus.sdram_cmd), 'b0010);
    check_eq("mid_rst_en", int'({bus.ref_en, bus.wr_en, bus.rd_en}), 0);
    s_rst_n = 1'b1;
    bus.flag_init_end = 1'b1;
    tick(1);
    check_eq("reinit_nop", int'(bus.sdram_cmd), int'(CMD_NOP));
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_eq("reinit_no_ref_en", int'(bus.ref_en), 0);
    end

    check_eq("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
